au_dec_seq: RTL and testbench
=============================

// Module: au_dec_seq
// PURPOSE
//   Sequential multi-word decrement controller. Decrements a WORD_W*NWORD-bit operand one word
//   per cycle through a single shared AU_dec_c instance, carrying the borrow in a register.
//   Stops at the first word that produces no borrow.
//   Sits between a valid/ready producer and consumer wherever a wide decrement is too costly in one cycle.
// PARAMETERS
//   WORD_W  8  word width; passed as WIDTH to the AU_dec_c instance
//   NWORD   4  number of words in the operand (>=1)
//   ARCH    0  architecture select; passed as ARCH to the AU_dec_c instance
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   rst_n      in   1                  reset, asynchronous, active-low
//   in_valid   in   1                  operand offered
//   in_ready   out  1                  block can accept; high only in IDLE
//   in_data    in   WORD_W*NWORD       operand; word 0 = LSBs
//   in_dec     in   1                  1 = decrement by one, 0 = pass through unchanged
//   out_valid  out  1                  result valid; held until out_ready
//   out_ready  in   1                  consumer accepts the result
//   out_data   out  WORD_W*NWORD       result
//   out_borrow out  1                  1 = underflow: operand was 0 and in_dec=1
//   out_nsteps out  $clog2(NWORD+1)    number of words passed through AU_dec_c
//   busy       out  1                  high in RUN or DONE
// BEHAVIOUR
//   - Reset: all outputs 0 except in_ready=1; state IDLE; operand, index and borrow registers cleared.
//   - AU_dec_c convention: ci=1 requests decrement; z = a - ci mod 2^WORD_W; co=1 iff a==0 && ci==1 (borrow out).
//     The block uses exactly one AU_dec_c instance, whose a input is the currently selected operand word.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: accept on in_valid && in_ready. Latch in_data, set idx=0, set nsteps=0, set borrow=in_dec.
//     If in_dec=1, go to RUN. If in_dec=0, go to DONE with data unchanged and out_borrow=0.
//   - RUN, each cycle: word[idx] <= z with ci=borrow; borrow <= co; nsteps <= nsteps+1.
//     If co==0 or idx==NWORD-1, go to DONE. Otherwise idx <= idx+1.
//     Words above the last processed word are never modified.
//   - DONE: out_valid=1; out_data, out_borrow and out_nsteps come from registers and stay stable until the handshake.
//     On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
//     The next accept occurs no earlier than the cycle after the handshake.
//   - Latency, counted from the accept edge to the first out_valid cycle: k+1 cycles where k = out_nsteps (1..NWORD).
//     With in_dec=0 the latency is 1 cycle.
//   - Underflow: the all-zero operand with in_dec=1 wraps to all-ones; out_borrow=1; out_nsteps=NWORD.
//   - in_valid in RUN or DONE is ignored and in_data is not sampled.
//     out_ready outside DONE has no effect.
//   - rst_n low in any state returns the block to reset values immediately (asynchronous).
//     Any in-flight operand is discarded and no result is produced for it.
//   - NWORD=1: RUN lasts exactly one cycle for any operand.
// TESTING (WORD_W=8, NWORD=4 unless noted)
//   1. in_data=0x00000100, dec=1 -> out_data 0x000000FF, borrow 0, nsteps 2, out_valid 3 cycles after accept
//   2. in_data=0x12345678, dec=1 -> 0x12345677, borrow 0, nsteps 1, latency 2
//   3. in_data=0x00000000, dec=1 -> 0xFFFFFFFF, borrow 1, nsteps 4, latency 5
//   4. in_data=0xDEADBEEF, dec=0 -> 0xDEADBEEF, borrow 0, nsteps 0, latency 1
//   5. out_ready held low 5 cycles and in_valid toggled in DONE -> outputs stable, in_ready 0, nothing accepted
//   6. rst_n pulsed low mid-RUN on 0x01000000 -> reset values at once; a following 0x00000001 dec=1 gives 0x00000000, nsteps 1
//   Finally, 10000 random operand/dec/backpressure transactions, checked against a (a - dec) mod 2^32 model.
//   Also repeat the sweep with NWORD=1, WORD_W=16.

Source files
------------

// File: rtl/au_dec_seq_if.sv
// rtl/au_dec_seq_if.sv - valid/ready operand and result bundle for au_dec_seq
// Producer side drives operands, consumer side takes results; busy mirrors the engine state.
interface au_dec_seq_if #(
  parameter int WORD_W = 8,
  parameter int NWORD  = 4
);
  localparam int DW   = WORD_W * NWORD;
  localparam int NS_W = $clog2(NWORD + 1);

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_dec;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_borrow;
  logic [NS_W-1:0] out_nsteps;
  logic            busy;

  modport master (
    output in_valid, in_data, in_dec, out_ready,
    input  in_ready, out_valid, out_data, out_borrow, out_nsteps, busy
  );

  modport slave (
    input  in_valid, in_data, in_dec, out_ready,
    output in_ready, out_valid, out_data, out_borrow, out_nsteps, busy
  );
endinterface

// File: rtl/au_dec_seq.sv
// rtl/au_dec_seq.sv - word-serial multi-word decrement through one shared AU_dec_c
// The borrow ripples one word per cycle and stops at the first word that absorbs it.
module au_dec_seq #(
  parameter int WORD_W = 8,
  parameter int NWORD  = 4,
  parameter int ARCH   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  au_dec_seq_if.slave bus
);
  localparam int DW    = WORD_W * NWORD;
  localparam int IDX_W = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int NS_W  = $clog2(NWORD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [DW-1:0]     r_data;
  logic [IDX_W-1:0]  r_idx;
  logic              r_borrow;
  logic [NS_W-1:0]   r_nsteps;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [WORD_W-1:0] w_a;
  logic [WORD_W-1:0] w_z;
  logic              w_co;

  assign w_a = r_data[int'(r_idx) * WORD_W +: WORD_W];

  AU_dec_c #(.WIDTH(WORD_W), .ARCH(ARCH)) u_dec (
    .a  (w_a),
    .ci (r_borrow),
    .z  (w_z),
    .co (w_co)
  );

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_data;
  assign bus.out_borrow = r_borrow;
  assign bus.out_nsteps = r_nsteps;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_idx       <= '0;
      r_borrow    <= 1'b0;
      r_nsteps    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_data     <= bus.in_data;
            r_idx      <= '0;
            r_nsteps   <= '0;
            r_borrow   <= bus.in_dec;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.in_dec) begin
              r_state <= S_RUN;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Words above the one where the borrow dies are left untouched.
          r_data[int'(r_idx) * WORD_W +: WORD_W] <= w_z;
          r_borrow <= w_co;
          r_nsteps <= r_nsteps + NS_W'(1);
          if (!w_co || r_idx == LAST_IDX) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// Single-word decrement cell: z = a - ci, co flags a borrow out of the word.
module AU_dec_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] z,
  output logic             co
);
  generate
    if (ARCH == 0) begin : g_sub
      assign {co, z} = {1'b0, a} - {{WIDTH{1'b0}}, ci};
    end else begin : g_add
      assign z  = a + {WIDTH{ci}};
      assign co = ci & ~(|a);
    end
  endgenerate
endmodule

// File: tb/tb_au_dec_seq.sv
// tb/tb_au_dec_seq.sv - randomized and directed check of au_dec_seq against an arithmetic model
// Two instances: 8x4 words and 16x1 word; sel picks which one the shared driver and monitor talk to.
module tb_au_dec_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic d_valid, d_dec, d_oready;
  logic [31:0] d_data;
  bit mon_en = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  au_dec_seq_if #(.WORD_W(8),  .NWORD(4)) ifa ();
  au_dec_seq_if #(.WORD_W(16), .NWORD(1)) ifb ();

  au_dec_seq #(.WORD_W(8),  .NWORD(4), .ARCH(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  au_dec_seq #(.WORD_W(16), .NWORD(1), .ARCH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  assign ifa.in_valid  = d_valid & ~sel;
  assign ifa.in_data   = d_data;
  assign ifa.in_dec    = d_dec;
  assign ifa.out_ready = d_oready & ~sel;
  assign ifb.in_valid  = d_valid & sel;
  assign ifb.in_data   = d_data[15:0];
  assign ifb.in_dec    = d_dec;
  assign ifb.out_ready = d_oready & sel;

  wire        s_in_ready   = sel ? ifb.in_ready   : ifa.in_ready;
  wire        s_out_valid  = sel ? ifb.out_valid  : ifa.out_valid;
  wire [31:0] s_out_data   = sel ? {16'h0, ifb.out_data} : ifa.out_data;
  wire        s_out_borrow = sel ? ifb.out_borrow : ifa.out_borrow;
  wire [2:0]  s_out_nsteps = sel ? {2'b00, ifb.out_nsteps} : ifa.out_nsteps;
  wire        s_busy       = sel ? ifb.busy       : ifa.busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Result from arithmetic: the borrow travels up through zero words, one step per word.
  function automatic void model(input logic [31:0] a, input logic dec, input logic b,
                                output logic [31:0] d, output logic bo,
                                output logic [2:0] ns, output int lat);
    int nw, ww, k;
    logic [31:0] mask, wm;
    nw   = b ? 1 : 4;
    ww   = b ? 16 : 8;
    mask = b ? 32'h0000FFFF : 32'hFFFFFFFF;
    wm   = b ? 32'h0000FFFF : 32'h000000FF;
    if (!dec) begin
      d = a; bo = 1'b0; ns = 3'd0; lat = 1;
    end else begin
      d  = (a - 32'd1) & mask;
      bo = (a == 32'd0);
      k  = 1;
      while (k < nw && ((a >> (ww * (k - 1))) & wm) == 32'd0) k++;
      ns  = 3'(k);
      lat = k + 1;
    end
  endfunction

  bit          m_pend = 1'b0;
  int          m_age, m_lat;
  logic [31:0] m_d;
  logic        m_b;
  logic [2:0]  m_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (mon_en) begin
      if (m_pend) begin
        m_age++;
        chk("mon.in_ready_busy", s_in_ready, 0);
        chk("mon.busy", s_busy, 1);
        chk("mon.out_valid", s_out_valid, (m_age >= m_lat) ? 1 : 0);
        if (m_age >= m_lat) begin
          chk("mon.out_data", s_out_data, m_d);
          chk("mon.out_borrow", s_out_borrow, m_b);
          chk("mon.out_nsteps", s_out_nsteps, m_n);
          if (d_oready) m_pend = 1'b0;
        end
      end else begin
        chk("mon.idle_in_ready", s_in_ready, 1);
        chk("mon.idle_out_valid", s_out_valid, 0);
        chk("mon.idle_busy", s_busy, 0);
        if (d_valid) begin
          model(sel ? {16'h0, d_data[15:0]} : d_data, d_dec, sel, m_d, m_b, m_n, m_lat);
          m_pend = 1'b1;
          m_age  = 0;
        end
      end
    end
  end

  // Called at posedge+1 with the block idle; returns one posedge+1 after the result handshake.
  task automatic xact(input logic [31:0] a, input logic dec, input int hold,
                      input bit noise, input bit rnd_rdy,
                      output logic [31:0] rd, output logic rb, output logic [2:0] rn, output int lat);
    int cyc, h;
    bit seen;
    h = hold; seen = 1'b0; cyc = 0;
    rd = '0; rb = 1'b0; rn = '0;
    d_valid = 1'b1; d_data = a; d_dec = dec; d_oready = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b0; d_data = $urandom; d_dec = 1'($urandom);
    lat = 1;
    forever begin
      if (s_out_valid && !seen) begin
        seen = 1'b1; rd = s_out_data; rb = s_out_borrow; rn = s_out_nsteps;
      end
      if (seen) begin
        d_oready = (h <= 0);
        h--;
      end else begin
        d_oready = rnd_rdy ? 1'($urandom) : 1'b0;
      end
      if (noise) begin
        d_valid = 1'($urandom); d_data = $urandom;
      end
      if (s_out_valid && d_oready) begin
        @(posedge clk); #1;
        break;
      end
      if (cyc >= 40) begin
        chk("xact.timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (!seen) lat++;
    end
    d_valid = 1'b0; d_oready = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [31:0] a, input logic dec,
                          input logic [31:0] ed, input logic eb, input logic [2:0] en,
                          input int elat, input int hold, input bit noise);
    logic [31:0] rd; logic rb; logic [2:0] rn; int lat;
    xact(a, dec, hold, noise, 1'b0, rd, rb, rn, lat);
    chk($sformatf("%s.data", nm), rd, ed);
    chk($sformatf("%s.borrow", nm), rb, eb);
    chk($sformatf("%s.nsteps", nm), rn, en);
    chk($sformatf("%s.latency", nm), lat, elat);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    for (int w = 0; w < 4; w++) v[w*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
    return v;
  endfunction

  initial begin
    logic [31:0] rd; logic rb; logic [2:0] rn; int lat;
    d_valid = 1'b0; d_data = '0; d_dec = 1'b0; d_oready = 1'b0;
    #12;
    chk("reset.in_ready", ifa.in_ready, 1);
    chk("reset.out_valid", ifa.out_valid, 0);
    chk("reset.busy", ifa.busy, 0);
    chk("reset.out_data", ifa.out_data, 0);
    chk("reset.out_borrow", ifa.out_borrow, 0);
    chk("reset.out_nsteps", ifa.out_nsteps, 0);
    chk("reset_b.in_ready", ifb.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    directed("t1", 32'h00000100, 1'b1, 32'h000000FF, 1'b0, 3'd2, 3, 0, 1'b0);
    directed("t2", 32'h12345678, 1'b1, 32'h12345677, 1'b0, 3'd1, 2, 0, 1'b0);
    directed("t3", 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 3'd4, 5, 0, 1'b0);
    directed("t4", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 3'd0, 1, 0, 1'b0);
    directed("t5", 32'h00000100, 1'b1, 32'h000000FF, 1'b0, 3'd2, 3, 5, 1'b1);
    directed("t5_next", 32'h00010000, 1'b1, 32'h0000FFFF, 1'b0, 3'd3, 4, 0, 1'b0);

    // Reset in the middle of a four-step ripple.
    d_valid = 1'b1; d_data = 32'h01000000; d_dec = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6.busy_before", ifa.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6.in_ready", ifa.in_ready, 1);
    chk("t6.out_valid", ifa.out_valid, 0);
    chk("t6.busy", ifa.busy, 0);
    chk("t6.out_data", ifa.out_data, 0);
    chk("t6.out_nsteps", ifa.out_nsteps, 0);
    chk("t6.out_borrow", ifa.out_borrow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6.no_result", ifa.out_valid, 0);
    end
    directed("t6_after", 32'h00000001, 1'b1, 32'h00000000, 1'b0, 3'd1, 2, 0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      xact(rnd_operand(), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2), 1'b1, 1'b1,
           rd, rb, rn, lat);
    end

    sel = 1'b1;
    @(posedge clk); #1;
    directed("b1", 32'h00000000, 1'b1, 32'h0000FFFF, 1'b1, 3'd1, 2, 0, 1'b0);
    directed("b2", 32'h00001234, 1'b1, 32'h00001233, 1'b0, 3'd1, 2, 0, 1'b0);
    directed("b3", 32'h0000BEEF, 1'b0, 32'h0000BEEF, 1'b0, 3'd0, 1, 2, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      xact(($urandom_range(0, 7) == 0) ? 32'h0 : {16'h0, 16'($urandom)},
           1'($urandom_range(0, 3) != 0), $urandom_range(0, 2), 1'b1, 1'b1, rd, rb, rn, lat);
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
